// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: bus address map, AHB encodings,
// receiver FSM states and the status-word layout.
package uart_rx_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [WORD_WIDTH-1:0] BUS_ADDR_UART_RECVDATA = 32'h4000_1008;
    localparam logic [WORD_WIDTH-1:0] BUS_ADDR_UART_RXSTATUS = 32'h4000_100C;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_CHECK,
        RX_STOP
    } rx_state_t;

    // flags = {timeout, overflow, frame_err, parity_err}, landing in [8:5]
    function automatic logic [WORD_WIDTH-1:0] pack_status(
        input logic       empty,
        input logic       full,
        input logic [2:0] usedw,
        input logic [3:0] flags,
        input logic       busy
    );
        return {22'd0, busy, flags, usedw, full, empty};
    endfunction

endpackage

// File: rtl/ip_uart_rx_fifo.sv
// 32-bit x 4 show-ahead FIFO: q always presents the head word, rdreq advances it.
module ip_uart_rx_fifo (
    input  logic        clock,
    input  logic [31:0] data,
    input  logic        rdreq,
    input  logic        sclr,
    input  logic        wrreq,
    output logic        empty,
    output logic        full,
    output logic [31:0] q,
    output logic [2:0]  usedw
);

    logic [31:0] mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;
    logic        do_wr;
    logic        do_rd;

    assign empty = (count == 3'd0);
    assign full  = (count == 3'd4);
    assign usedw = count;
    assign q     = mem[rd_ptr];

    assign do_wr = wrreq && !full;
    assign do_rd = rdreq && !empty;

    always_ff @(posedge clock) begin
        if (sclr) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with AHB-lite slave: deserialises checked frames, packs four
// bytes little-endian into a word FIFO, and reports status/errors/interrupt.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BPS_115200        = 434,
    parameter int UART_SYMBOL_WIDTH = 11,
    parameter int IDLE_TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hsel_rx,
    input  logic [WORD_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic [WORD_WIDTH-1:0] HWDATA,
    input  logic                  uartRx_int_clear,
    input  logic                  RX,
    output logic [WORD_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic [1:0]            HRESP,
    output logic                  irq_uartRx
);

    localparam int                CNT_W      = $clog2(BPS_115200);
    localparam logic [CNT_W-1:0]  HALF_END   = CNT_W'(BPS_115200 / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_END    = CNT_W'(BPS_115200 - 1);
    localparam int                DATA_BITS  = UART_SYMBOL_WIDTH - 3;
    localparam logic [2:0]        LAST_BIT   = 3'(DATA_BITS - 1);
    localparam int                TMO_CYCLES = IDLE_TIMEOUT_BITS * BPS_115200;
    localparam int                TMO_W      = $clog2(TMO_CYCLES);
    localparam logic [TMO_W-1:0]  TMO_END    = TMO_W'(TMO_CYCLES - 1);

    logic rx_meta, rx_sync, rx_prev, fall;

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic             sample;
    logic [7:0]       shift;
    logic             check_bit;

    logic [1:0]       byte_idx;
    logic [23:0]      lanes;
    logic [TMO_W-1:0] idle_cnt;
    logic             push_q;
    logic [31:0]      push_word;

    logic flag_parity, flag_frame, flag_overflow, flag_timeout;
    logic stop_sample, par_ok, byte_good, word_done, tmo_hit;
    logic set_parity, set_frame, set_overflow, set_timeout;
    logic [3:0] w1c;
    logic       stat_wr_q;
    logic       irq_set;

    logic        fifo_rdreq, fifo_empty, fifo_full, fifo_sclr;
    logic [31:0] fifo_q;
    logic [2:0]  fifo_usedw;

    logic xfer, hit_data, hit_stat;
    logic [WORD_WIDTH-1:0] status_word;

    logic unused_ok;
    assign unused_ok = ^{HSIZE, HBURST, HMASTLOCK, HWDATA[31:9], HWDATA[4:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        unique case (state)
            RX_IDLE:  if (fall) state_next = RX_START;
            RX_START: if (cnt == HALF_END) begin
                sample     = 1'b1;
                state_next = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA:  if (cnt == BIT_END) begin
                sample = 1'b1;
                if (bit_cnt == LAST_BIT) state_next = RX_CHECK;
            end
            RX_CHECK: if (cnt == BIT_END) begin
                sample     = 1'b1;
                state_next = RX_STOP;
            end
            RX_STOP:  if (cnt == BIT_END) begin
                sample     = 1'b1;
                state_next = RX_IDLE;
            end
            default:  state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= 3'd0;
            shift     <= 8'd0;
            check_bit <= 1'b0;
        end else begin
            cnt <= (state == RX_IDLE || sample) ? '0 : cnt + 1'b1;
            if (state == RX_DATA && sample) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == RX_CHECK && sample) check_bit <= rx_sync;
        end
    end

    assign stop_sample  = (state == RX_STOP) && sample;
    assign par_ok       = (check_bit == ^shift);
    assign byte_good    = stop_sample && par_ok && rx_sync;
    assign set_parity   = stop_sample && !par_ok;
    assign set_frame    = stop_sample && !rx_sync;
    assign word_done    = byte_good && (byte_idx == 2'd3);
    assign set_overflow = word_done && fifo_full;
    assign tmo_hit      = (state == RX_IDLE) && (byte_idx != 2'd0) && rx_sync
                          && (idle_cnt == TMO_END);
    assign set_timeout  = tmo_hit;

    // Any error or timeout abandons the partial word so the next good byte is lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= 2'd0;
            lanes     <= 24'd0;
            idle_cnt  <= '0;
            push_q    <= 1'b0;
            push_word <= 32'd0;
        end else begin
            push_q <= word_done && !fifo_full;
            if (word_done) push_word <= {shift, lanes};
            if (set_parity || set_frame || tmo_hit) begin
                byte_idx <= 2'd0;
            end else if (byte_good) begin
                case (byte_idx)
                    2'd0:    lanes[7:0]   <= shift;
                    2'd1:    lanes[15:8]  <= shift;
                    2'd2:    lanes[23:16] <= shift;
                    default: lanes        <= lanes;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == RX_IDLE && byte_idx != 2'd0 && rx_sync && !tmo_hit)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;
        end
    end

    assign w1c = stat_wr_q ? HWDATA[8:5] : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_parity   <= 1'b0;
            flag_frame    <= 1'b0;
            flag_overflow <= 1'b0;
            flag_timeout  <= 1'b0;
            irq_uartRx    <= 1'b0;
        end else begin
            flag_parity   <= set_parity   || (flag_parity   && !w1c[0]);
            flag_frame    <= set_frame    || (flag_frame    && !w1c[1]);
            flag_overflow <= set_overflow || (flag_overflow && !w1c[2]);
            flag_timeout  <= set_timeout  || (flag_timeout  && !w1c[3]);
            irq_uartRx    <= irq_set || (irq_uartRx && !uartRx_int_clear);
        end
    end

    assign irq_set = push_q
                     || (set_parity   && !flag_parity)
                     || (set_frame    && !flag_frame)
                     || (set_overflow && !flag_overflow)
                     || (set_timeout  && !flag_timeout);

    // A transfer is taken in its address phase; HREADY/HRESP/HRDATA answer it
    // one cycle later, and a RECVDATA read pops the FIFO in the address phase.
    assign xfer       = hsel_rx && (HTRANS == HTRANS_NONSEQ);
    assign hit_data   = (HADDR == BUS_ADDR_UART_RECVDATA);
    assign hit_stat   = (HADDR == BUS_ADDR_UART_RXSTATUS);
    assign fifo_rdreq = xfer && !HWRITE && hit_data && !fifo_empty;
    assign fifo_sclr  = !rst_n;

    assign status_word = pack_status(fifo_empty, fifo_full, fifo_usedw,
                                     {flag_timeout, flag_overflow, flag_frame, flag_parity},
                                     state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            HRDATA    <= '0;
            HREADY    <= 1'b0;
            HRESP     <= HRESP_ERROR;
            stat_wr_q <= 1'b0;
        end else begin
            stat_wr_q <= xfer && HWRITE && hit_stat;
            HREADY    <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            if (xfer) begin
                if (hit_data && HWRITE) begin
                    HREADY <= 1'b0;
                    HRESP  <= HRESP_ERROR;
                end else if (hit_data && !fifo_empty) begin
                    HRDATA <= fifo_q;
                end else if (hit_stat && !HWRITE) begin
                    HRDATA <= status_word;
                end
            end
        end
    end

    ip_uart_rx_fifo u_fifo (
        .clock (clk),
        .data  (push_word),
        .rdreq (fifo_rdreq),
        .sclr  (fifo_sclr),
        .wrreq (push_q),
        .empty (fifo_empty),
        .full  (fifo_full),
        .q     (fifo_q),
        .usedw (fifo_usedw)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: random and directed frames on RX, a queue-based reference
// model of the word FIFO and flags, and a monitor scoring every read response.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BPS      = 16;
    localparam int TMO_BITS = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsel_rx = 1'b0;
    logic [31:0] HADDR = 32'd0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [2:0]  HBURST = 3'b000;
    logic [1:0]  HTRANS = 2'b00;
    logic        HMASTLOCK = 1'b0;
    logic [31:0] HWDATA = 32'd0;
    logic        uartRx_int_clear = 1'b0;
    logic        RX = 1'b1;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic        irq_uartRx;

    uart_rx #(
        .BPS_115200        (BPS),
        .UART_SYMBOL_WIDTH (11),
        .IDLE_TIMEOUT_BITS (TMO_BITS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hsel_rx          (hsel_rx),
        .HADDR            (HADDR),
        .HWRITE           (HWRITE),
        .HSIZE            (HSIZE),
        .HBURST           (HBURST),
        .HTRANS           (HTRANS),
        .HMASTLOCK        (HMASTLOCK),
        .HWDATA           (HWDATA),
        .uartRx_int_clear (uartRx_int_clear),
        .RX               (RX),
        .HRDATA           (HRDATA),
        .HREADY           (HREADY),
        .HRESP            (HRESP),
        .irq_uartRx       (irq_uartRx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_fifo[$];
    logic [7:0]  part_q[$];
    bit m_par, m_frame, m_ovf, m_tmo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model
    function automatic void model_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [31:0] w;
        if (bad_par || bad_stop) begin
            if (bad_par)  m_par = 1'b1;
            if (bad_stop) m_frame = 1'b1;
            part_q.delete();
            return;
        end
        part_q.push_back(b);
        if (part_q.size() == 4) begin
            w = {part_q[3], part_q[2], part_q[1], part_q[0]};
            if (model_fifo.size() < 4) model_fifo.push_back(w);
            else                       m_ovf = 1'b1;
            part_q.delete();
        end
    endfunction

    function automatic void model_timeout();
        if (part_q.size() != 0) begin
            part_q.delete();
            m_tmo = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        model_fifo.delete();
        part_q.delete();
        m_par = 1'b0; m_frame = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0;
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        n = model_fifo.size();
        return {22'd0, 1'b0, m_tmo, m_ovf, m_frame, m_par, 3'(n), n == 4, n == 0};
    endfunction

    // Drivers
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int abort_at);
        logic [10:0] bits;
        bits = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11 * BPS; i++) begin
            if (i == abort_at) return;
            @(negedge clk);
            RX = bits[i / BPS];
        end
        @(negedge clk);
        RX = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        model_byte(b, bad_par, bad_stop);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, -1);
    endtask

    task automatic send_word_rand();
        for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    endtask

    task automatic bus_read(input logic [31:0] addr);
        @(negedge clk);
        if (addr == BUS_ADDR_UART_RECVDATA) begin
            if (model_fifo.size() != 0) exp_q.push_back(model_fifo.pop_front());
            else                        exp_q.push_back(32'd0);
        end else begin
            exp_q.push_back(model_status());
        end
        hsel_rx = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = 1'b0;
        @(negedge clk);
        hsel_rx = 1'b0; HTRANS = 2'b00;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                             output logic ready, output logic [1:0] resp);
        @(negedge clk);
        hsel_rx = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = 1'b1;
        @(negedge clk);
        hsel_rx = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
        ready = HREADY;
        resp  = HRESP;
        @(negedge clk);
        HWDATA = 32'd0;
    endtask

    // Monitor: every read data phase pops one expected word
    logic        dp_read = 1'b0;
    logic [31:0] exp_word;

    always @(posedge clk) dp_read <= hsel_rx && (HTRANS == HTRANS_NONSEQ) && !HWRITE;

    always @(negedge clk) begin
        if (dp_read) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: read response %h with no expected entry", HRDATA);
            end else begin
                exp_word = exp_q.pop_front();
                check("read_data", HRDATA, exp_word);
                check("read_okay", {29'd0, HREADY, HRESP}, 32'h4);
            end
        end
    end

    logic        w_ready;
    logic [1:0]  w_resp;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_hready", {31'd0, HREADY}, 32'd0);
        check("reset_hresp", {30'd0, HRESP}, {30'd0, HRESP_ERROR});
        check("reset_hrdata", HRDATA, 32'd0);
        check("reset_irq", {31'd0, irq_uartRx}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready_okay", {29'd0, HREADY, HRESP}, 32'h4);
        bus_read(BUS_ADDR_UART_RXSTATUS);

        // Loopback-style word
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("irq_after_push", {31'd0, irq_uartRx}, 32'd1);
        check("model_word", model_fifo[0], 32'hDEADBEEF);
        bus_read(BUS_ADDR_UART_RECVDATA);
        bus_read(BUS_ADDR_UART_RXSTATUS);
        @(negedge clk) uartRx_int_clear = 1'b1;
        @(negedge clk) uartRx_int_clear = 1'b0;
        check("irq_cleared", {31'd0, irq_uartRx}, 32'd0);

        // Parity error discards the partial word
        send_byte(8'h78);
        send_frame(8'h56, 1'b1, 1'b0, -1);
        send_byte(8'h34); send_byte(8'h12);
        for (int k = 1; k <= 4; k++) send_byte(8'(k));
        while (part_q.size() != 0) send_byte(8'($urandom));
        bus_read(BUS_ADDR_UART_RXSTATUS);
        while (model_fifo.size() != 0) bus_read(BUS_ADDR_UART_RECVDATA);
        bus_write(BUS_ADDR_UART_RXSTATUS, 32'h20, w_ready, w_resp);
        check("status_write_okay", {29'd0, w_ready, w_resp}, 32'h4);
        m_par = 1'b0;
        bus_read(BUS_ADDR_UART_RXSTATUS);

        // Stop-bit error
        send_byte(8'($urandom));
        send_frame(8'($urandom), 1'b0, 1'b1, -1);
        bus_read(BUS_ADDR_UART_RXSTATUS);
        bus_write(BUS_ADDR_UART_RXSTATUS, 32'h40, w_ready, w_resp);
        m_frame = 1'b0;

        // Short glitch is a false start
        @(negedge clk) RX = 1'b0;
        repeat (BPS / 4) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BPS) @(negedge clk);
        bus_read(BUS_ADDR_UART_RXSTATUS);

        // Five words without reads: overflow on the fifth
        for (int w = 0; w < 5; w++) send_word_rand();
        bus_read(BUS_ADDR_UART_RXSTATUS);
        for (int r = 0; r < 4; r++) bus_read(BUS_ADDR_UART_RECVDATA);
        bus_write(BUS_ADDR_UART_RXSTATUS, 32'h80, w_ready, w_resp);
        m_ovf = 1'b0;
        bus_read(BUS_ADDR_UART_RXSTATUS);

        // Idle timeout with two bytes pending
        send_byte(8'($urandom)); send_byte(8'($urandom));
        repeat (TMO_BITS * BPS + 2 * BPS) @(negedge clk);
        model_timeout();
        bus_read(BUS_ADDR_UART_RXSTATUS);
        send_word_rand();
        bus_read(BUS_ADDR_UART_RECVDATA);
        bus_write(BUS_ADDR_UART_RXSTATUS, 32'h100, w_ready, w_resp);
        m_tmo = 1'b0;
        bus_read(BUS_ADDR_UART_RXSTATUS);

        // Write to the data register is an error
        bus_write(BUS_ADDR_UART_RECVDATA, 32'h1234_5678, w_ready, w_resp);
        check("data_write_error", {29'd0, w_ready, w_resp}, {29'd0, 1'b0, HRESP_ERROR});

        // Reset in the middle of the second byte
        send_word_rand();
        send_byte(8'($urandom));
        send_frame(8'($urandom), 1'b0, 1'b0, 4 * BPS + 3);
        RX = 1'b1;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midreset_hready", {31'd0, HREADY}, 32'd0);
        check("midreset_hresp", {30'd0, HRESP}, {30'd0, HRESP_ERROR});
        check("midreset_hrdata", HRDATA, 32'd0);
        check("midreset_irq", {31'd0, irq_uartRx}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(BUS_ADDR_UART_RXSTATUS);
        send_word_rand();
        bus_read(BUS_ADDR_UART_RECVDATA);

        // Random words, then a read of the empty FIFO
        for (int w = 0; w < 3; w++) begin
            send_word_rand();
            bus_read(BUS_ADDR_UART_RECVDATA);
        end
        bus_read(BUS_ADDR_UART_RECVDATA);
        bus_read(BUS_ADDR_UART_RXSTATUS);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
